bf_loop_stack: RTL and testbench

//  Loop-control unit for the BF machine: a parametrised successor to the single
//  PC/bracket-count registers. Combines a LIFO of '[' return addresses with a

---
 rtl/bf_loop_stack.sv | 96 +++++++++
 tb/tb_bf_loop_stack.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bf_loop_stack.sv
// bf_loop_stack: loop return-address stack plus forward-skip nesting counter; BF_LOOP_ERR_CLR_EN adds err_clr
module bf_loop_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    output logic [ADDR_W-1:0]          top_addr,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    input  logic                       skip_start,
    input  logic                       skip_open,
    input  logic                       skip_close,
    output logic                       skipping,
    output logic                       skip_done,
    output logic                       ovf,
`ifdef BF_LOOP_ERR_CLR_EN
    output logic                       unf,
    input  logic                       err_clr
`else
    output logic                       unf
`endif
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic IDLE = 1'b0;
    localparam logic SKIP = 1'b1;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] nest;
    logic state;
    logic [AW-1:0] top_idx;
    logic replace, grow, wr_en;
    logic [AW-1:0] wr_idx;
    assign empty    = depth == '0;
    assign full     = depth == DW'(DEPTH);
    assign skipping = state == SKIP;
    assign top_idx  = AW'(depth - DW'(1));
    assign top_addr = empty ? '0 : mem[top_idx];
    always_comb begin
        replace = !skipping && push && pop && !empty;
        grow    = !skipping && push && !replace && !full;
        wr_en   = replace || grow;
        wr_idx  = replace ? top_idx : AW'(depth);
    end
    always_ff @(posedge clock)
        if (!reset && wr_en)
            mem[wr_idx] <= push_addr;
    always_ff @(posedge clock) begin
        if (reset) begin
            depth     <= '0;
            state     <= IDLE;
            nest      <= '0;
            skip_done <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            skip_done <= 1'b0;
            if (state == IDLE) begin
                if (grow)
                    depth <= depth + DW'(1);
                else if (push && !replace)
                    ovf <= 1'b1;
                else if (pop && !push && !empty)
                    depth <= depth - DW'(1);
                else if (pop && !push)
                    unf <= 1'b1;
                if (skip_start) begin
                    state <= SKIP;
                    nest  <= CNT_W'(1);
                end
            end else if (skip_open && !skip_close) begin
                if (&nest)
                    ovf <= 1'b1;
                else
                    nest <= nest + CNT_W'(1);
            end else if (skip_close && !skip_open) begin
                nest <= nest - CNT_W'(1);
                if (nest == CNT_W'(1)) begin
                    state     <= IDLE;
                    skip_done <= 1'b1;
                end
            end
`ifdef BF_LOOP_ERR_CLR_EN
            if (err_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_bf_loop_stack.sv
// tb_bf_loop_stack: directed and random stimulus against a queue-based reference model
module tb_bf_loop_stack;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int DW = $clog2(DEPTH + 1);
    localparam int MAXN = (1 << CNT_W) - 1;
    logic clock = 1'b0;
    logic reset, push, pop, skip_start, skip_open, skip_close, err_clr;
    logic [7:0] push_addr, top_addr;
    logic [DW-1:0] depth;
    logic empty, full, skipping, skip_done, ovf, unf;
    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    bit m_sk, m_done, m_ovf, m_unf;
    int m_nest;

    always #5 clock = ~clock;

    bf_loop_stack #(.ADDR_W(8), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .push(push), .pop(pop), .push_addr(push_addr),
        .top_addr(top_addr), .depth(depth), .empty(empty), .full(full),
        .skip_start(skip_start), .skip_open(skip_open), .skip_close(skip_close),
        .skipping(skipping), .skip_done(skip_done), .ovf(ovf),
`ifdef BF_LOOP_ERR_CLR_EN
        .unf(unf), .err_clr(err_clr)
`else
        .unf(unf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit pu, po, input logic [7:0] pa, input bit ss, so, sc, rs, ec);
        if (rs) begin
            q.delete();
            {m_sk, m_done, m_ovf, m_unf} = '0;
            m_nest = 0;
            return;
        end
        m_done = 0;
        if (!m_sk) begin
            if (pu && po && q.size() > 0) q[q.size()-1] = pa;
            else if (pu) begin
                if (q.size() < DEPTH) q.push_back(pa);
                else m_ovf = 1;
            end else if (po) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_unf = 1;
            end
            if (ss) begin
                m_sk = 1;
                m_nest = 1;
            end
        end else if (so && !sc) begin
            if (m_nest == MAXN) m_ovf = 1;
            else m_nest++;
        end else if (sc && !so) begin
            m_nest--;
            if (m_nest == 0) begin
                m_sk = 0;
                m_done = 1;
            end
        end
`ifdef BF_LOOP_ERR_CLR_EN
        if (ec) begin
            m_ovf = 0;
            m_unf = 0;
        end
`endif
    endtask

    task automatic cyc(input bit pu, po, input logic [7:0] pa, input bit ss, so, sc, rs, ec);
        logic [7:0] etop;
        {push, pop, push_addr, skip_start, skip_open, skip_close, reset, err_clr} = {pu, po, pa, ss, so, sc, rs, ec};
        @(posedge clock);
        model(pu, po, pa, ss, so, sc, rs, ec);
        #1;
        etop = q.size() > 0 ? q[q.size()-1] : 8'h00;
        chk("top_addr", top_addr, etop);
        chk("depth", depth, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("skipping", skipping, m_sk);
        chk("skip_done", skip_done, m_done);
        chk("ovf", ovf, m_ovf);
        chk("unf", unf, m_unf);
    endtask

    initial begin
        {push, pop, push_addr, skip_start, skip_open, skip_close, reset, err_clr} = '0;
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_empty", empty, 1);
        cyc(1, 0, 8'h05, 0, 0, 0, 0, 0);
        cyc(1, 0, 8'h12, 0, 0, 0, 0, 0);
        cyc(1, 0, 8'h30, 0, 0, 0, 0, 0);
        chk("dir_depth3", depth, 3);
        chk("dir_top30", top_addr, 8'h30);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("dir_pop_top12", top_addr, 8'h12);
        cyc(1, 1, 8'h44, 0, 0, 0, 0, 0);
        chk("dir_replace_top", top_addr, 8'h44);
        chk("dir_replace_depth", depth, 2);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("dir_unf", unf, 1);
        chk("dir_unf_depth", depth, 0);
        cyc(1, 1, 8'h21, 0, 0, 0, 0, 0);
        chk("dir_pp_empty_depth", depth, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, 8'(i), 0, 0, 0, 0, 0);
        cyc(1, 0, 8'hAA, 0, 0, 0, 0, 0);
        chk("dir_full", full, 1);
        chk("dir_ovf", ovf, 1);
        chk("dir_full_top", top_addr, DEPTH);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("dir_rst_ovf", ovf, 0);
        cyc(1, 0, 8'h10, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 8'h66, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("dir_no_early_done", skip_done, 0);
        cyc(1, 0, 8'h77, 0, 0, 1, 0, 0);
        chk("dir_skip_done", skip_done, 1);
        chk("dir_skip_push_ignored", depth, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("dir_done_pulse", skip_done, 0);
        chk("dir_skip_end", skipping, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("dir_nest_ovf", ovf, 1);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        chk("dir_rst_skip", skipping, 0);
`ifdef BF_LOOP_ERR_CLR_EN
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("dir_unf_set", unf, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("dir_err_clr", unf, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("dir_err_clr_prio", unf, 0);
`endif
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
